// File: rtl/riscv_mpsoc_pkg.sv
// Shared core constants: PMP CSR addresses, PMP address-match modes,
// privilege levels and CSR operation encodings.
package riscv_mpsoc_pkg;

  localparam logic [11:0] PMPCFG0      = 12'h3A0;
  localparam logic [11:0] PMPADDR0     = 12'h3B0;
  localparam logic [11:0] PMP_CSR_LAST = 12'h3EF;

  typedef enum logic [1:0] {
    PMP_A_OFF   = 2'b00,
    PMP_A_TOR   = 2'b01,
    PMP_A_NA4   = 2'b10,
    PMP_A_NAPOT = 2'b11
  } pmp_a_e;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  function automatic logic [63:0] csr_apply_op(input csr_op_e op,
                                               input logic [63:0] old_val,
                                               input logic [63:0] operand);
    logic [63:0] res;
    unique case (op)
      CSR_OP_WRITE: res = operand;
      CSR_OP_SET:   res = old_val | operand;
      CSR_OP_CLEAR: res = old_val & ~operand;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_pmpcfg_warl.sv
// One pmpcfg byte: applies lock and WARL legalisation to a proposed new value.
module riscv_pmpcfg_warl (
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  input  logic       lock_i,
  output logic [7:0] cfg_o
);

  logic reserved_rw;

  // R=0,W=1 is a reserved combination; the whole byte falls back to its old value.
  assign reserved_rw = (new_i[1:0] == 2'b10);

  always_comb begin
    cfg_o = old_i;
    if (!lock_i && !reserved_rw) begin
      cfg_o = {new_i[7], 2'b00, new_i[4:0]};
    end
  end

endmodule

// File: rtl/riscv_pmpcsr.sv
// PMP CSR register file: pmpcfg/pmpaddr storage, CSR access handshake,
// WARL and lock enforcement, and the packed state seen by the PMP checker.
//
// state  | meaning
// IDLE   | waiting for a request in the PMP CSR window
// RESP   | ack pulse; write already committed, rdata/illegal valid
module riscv_pmpcsr
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int PMP_CNT = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             csr_req_i,
  input  logic [11:0]                                      csr_adr_i,
  input  logic [1:0]                                       csr_op_i,
  input  logic [XLEN-1:0]                                  csr_wdata_i,
  input  logic [1:0]                                       st_prv_i,
  output logic                                             csr_ack_o,
  output logic [XLEN-1:0]                                  csr_rdata_o,
  output logic                                             csr_illegal_o,
  output logic [((PMP_CNT > 0) ? PMP_CNT : 1)-1:0][7:0]     st_pmpcfg_o,
  output logic [((PMP_CNT > 0) ? PMP_CNT : 1)-1:0][XLEN-1:0] st_pmpaddr_o
);

  localparam int NE = (PMP_CNT > 0) ? PMP_CNT : 1;
  localparam int NB = XLEN / 8;
  localparam int AW = (XLEN < PLEN - 2) ? XLEN : PLEN - 2;
  localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} >> (XLEN - AW);

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic [NE-1:0][7:0]        cfg_q, cfg_d;
  logic [NE-1:0][XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]           rdata_q, rdata_d;
  logic                      illegal_q, illegal_d;

  logic        in_range, is_cfg, illegal, acc_hit, wr_en;
  int          cfg_base, addr_idx;
  logic [7:0]  cfg_old_b [8];
  logic [7:0]  cfg_new_b [8];
  logic [63:0] old_word, new_word;
  logic [NE-1:0] addr_lock;

  always_comb begin
    in_range = (csr_adr_i >= PMPCFG0) && (csr_adr_i <= PMP_CSR_LAST);
    is_cfg   = (csr_adr_i < PMPADDR0);
    cfg_base = int'({csr_adr_i[3:0], 2'b00});
    addr_idx = int'(csr_adr_i - PMPADDR0);
    illegal  = (st_prv_i != PRV_M) || ((XLEN == 64) && is_cfg && csr_adr_i[0]);
    acc_hit  = (state_q == S_IDLE) && csr_req_i && in_range;
    wr_en    = acc_hit && !illegal && (csr_op_e'(csr_op_i) != CSR_OP_READ);

    for (int k = 0; k < 8; k++) begin
      cfg_old_b[k] = 8'h00;
      for (int i = 0; i < PMP_CNT; i++) begin
        if ((k < NB) && (cfg_base + k == i)) cfg_old_b[k] = cfg_q[i];
      end
    end

    old_word = '0;
    if (is_cfg) begin
      for (int k = 0; k < 8; k++) old_word[8*k +: 8] = cfg_old_b[k];
    end else begin
      for (int i = 0; i < PMP_CNT; i++) begin
        if (addr_idx == i) old_word = 64'(addr_q[i]);
      end
    end
    new_word = csr_apply_op(csr_op_e'(csr_op_i), old_word, 64'(csr_wdata_i));

    // An entry's address is frozen by its own lock or by a locked TOR entry above it.
    addr_lock = '0;
    for (int i = 0; i < PMP_CNT; i++) addr_lock[i] = cfg_q[i][7];
    for (int i = 0; i < PMP_CNT - 1; i++) begin
      if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == PMP_A_TOR)) addr_lock[i] = 1'b1;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_warl
    riscv_pmpcfg_warl u_warl (
      .old_i  (cfg_old_b[k]),
      .new_i  (new_word[8*k +: 8]),
      .lock_i (cfg_old_b[k][7]),
      .cfg_o  (cfg_new_b[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc_hit) begin
          state_d   = S_RESP;
          illegal_d = illegal;
          rdata_d   = illegal ? '0 : old_word[XLEN-1:0];
          for (int i = 0; i < PMP_CNT; i++) begin
            for (int k = 0; k < NB; k++) begin
              if (wr_en && is_cfg && (cfg_base + k == i)) cfg_d[i] = cfg_new_b[k];
            end
            if (wr_en && !is_cfg && (addr_idx == i) && !addr_lock[i]) begin
              addr_d[i] = new_word[XLEN-1:0] & ADDR_MASK;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
    end
  end

  assign csr_ack_o     = (state_q == S_RESP);
  assign csr_rdata_o   = rdata_q;
  assign csr_illegal_o = illegal_q;
  assign st_pmpcfg_o   = cfg_q;
  assign st_pmpaddr_o  = addr_q;

endmodule

// File: tb/tb_riscv_pmpcsr.sv
// Self-checking bench for riscv_pmpcsr: directed vector table, handshake and
// reset corner sequences, then random accesses against a behavioural model.
module tb_riscv_pmpcsr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [11:0] adr = '0;
  logic [1:0]  op  = '0;
  logic [63:0] wd  = '0;
  logic [1:0]  prv = 2'b11;
  logic        ack;
  logic [63:0] rdata;
  logic        ill;
  logic [15:0][7:0]  st_cfg;
  logic [15:0][63:0] st_addr;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_cfg  [16];
  logic [63:0] m_addr [16];

  typedef struct {
    logic [11:0] adr;
    logic [1:0]  op;
    logic [63:0] wd;
    logic [1:0]  prv;
    logic [63:0] rd;
    logic        ill;
  } vec_t;
  vec_t tbl[$];

  riscv_pmpcsr #(.XLEN(64), .PLEN(64), .PMP_CNT(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .csr_req_i     (req),
    .csr_adr_i     (adr),
    .csr_op_i      (op),
    .csr_wdata_i   (wd),
    .st_prv_i      (prv),
    .csr_ack_o     (ack),
    .csr_rdata_o   (rdata),
    .csr_illegal_o (ill),
    .st_pmpcfg_o   (st_cfg),
    .st_pmpaddr_o  (st_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm);
    int err;
    err = -1;
    total++;
    for (int i = 0; i < 16; i++) begin
      if (err < 0 && (st_cfg[i] !== m_cfg[i] || st_addr[i] !== m_addr[i])) err = i;
    end
    if (err >= 0) begin
      bad++;
      $display("FAIL %s: entry %0d cfg %h addr %h expected cfg %h addr %h", nm, err,
               st_cfg[err], st_addr[err], m_cfg[err], m_addr[err]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 64'h0;
    end
  endtask

  // Architectural view: an access returns the old CSR image, then each
  // implemented byte/entry takes the new value unless locked or reserved.
  task automatic model(input logic [11:0] a, input logic [1:0] o, input logic [63:0] w,
                       input logic [1:0] p, output logic [63:0] rd, output logic il);
    logic [63:0] old, nw;
    logic [7:0]  b;
    int base, e, idx;
    logic locked;
    rd = 64'h0;
    il = 1'b0;
    if (p != 2'b11 || (a >= 12'h3A0 && a <= 12'h3AF && a[0])) begin
      il = 1'b1;
      return;
    end
    old = 64'h0;
    if (a <= 12'h3AF) begin
      base = 4 * int'(a - 12'h3A0);
      for (int k = 0; k < 8; k++) if (base + k < 16) old[8*k +: 8] = m_cfg[base + k];
    end else begin
      idx = int'(a - 12'h3B0);
      if (idx < 16) old = m_addr[idx];
    end
    case (o)
      2'd1:    nw = w;
      2'd2:    nw = old | w;
      2'd3:    nw = old & ~w;
      default: nw = old;
    endcase
    rd = old;
    if (o == 2'd0) return;
    if (a <= 12'h3AF) begin
      for (int k = 0; k < 8; k++) begin
        e = base + k;
        b = nw[8*k +: 8];
        if (e < 16 && !m_cfg[e][7] && !(b[1] && !b[0])) m_cfg[e] = b & 8'h9F;
      end
    end else if (idx < 16) begin
      locked = m_cfg[idx][7];
      if (idx < 15 && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'b01) locked = 1'b1;
      if (!locked) m_addr[idx] = nw & 64'h3FFF_FFFF_FFFF_FFFF;
    end
  endtask

  task automatic run_access(input logic [11:0] a, input logic [1:0] o, input logic [63:0] w,
                            input logic [1:0] p, output logic [63:0] rd, output logic il,
                            output logic ak);
    @(negedge clk);
    req = 1'b1; adr = a; op = o; wd = w; prv = p;
    @(posedge clk); #1;
    ak = ack; rd = rdata; il = ill;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_single_pulse", ack, 1'b0);
  endtask

  task automatic add(input logic [11:0] a, input logic [1:0] o, input logic [63:0] w,
                     input logic [1:0] p, input logic [63:0] r, input logic i);
    vec_t v;
    v.adr = a; v.op = o; v.wd = w; v.prv = p; v.rd = r; v.ill = i;
    tbl.push_back(v);
  endtask

  initial begin
    logic [63:0] rd, mrd;
    logic        il, mil, ak;
    logic [11:0] a;
    logic [1:0]  o, p;
    logic [63:0] w;
    int r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", ack, 1'b0);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_illegal", ill, 1'b0);
    chk_state("reset_state");
    @(negedge clk);
    rst = 1'b0;

    add(12'h3A0, 2'd1, 64'h0000_0000_0000_1F0F, 2'b11, 64'h0, 1'b0);
    add(12'h3A0, 2'd0, 64'h0, 2'b11, 64'h0000_0000_0000_1F0F, 1'b0);
    add(12'h3B3, 2'd1, 64'h1234, 2'b11, 64'h0, 1'b0);
    add(12'h3A0, 2'd1, 64'h0000_0000_8900_1F0F, 2'b11, 64'h0000_0000_0000_1F0F, 1'b0);
    add(12'h3B3, 2'd1, 64'hFFFF, 2'b11, 64'h1234, 1'b0);
    add(12'h3B2, 2'd1, 64'hFFFF, 2'b11, 64'h0, 1'b0);
    add(12'h3B3, 2'd0, 64'hFFFF, 2'b11, 64'h1234, 1'b0);
    add(12'h3B2, 2'd0, 64'h0, 2'b11, 64'h0, 1'b0);
    add(12'h3A0, 2'd1, 64'h0000_0100_8900_1F0F, 2'b11, 64'h0000_0000_8900_1F0F, 1'b0);
    add(12'h3A0, 2'd1, 64'h0003_0200_8900_1F0F, 2'b11, 64'h0000_0100_8900_1F0F, 1'b0);
    add(12'h3A0, 2'd0, 64'h0, 2'b11, 64'h0003_0100_8900_1F0F, 1'b0);
    add(12'h3B0, 2'd1, 64'h55, 2'b00, 64'h0, 1'b1);
    add(12'h3B0, 2'd0, 64'h0, 2'b11, 64'h0, 1'b0);
    add(12'h3A1, 2'd0, 64'h0, 2'b11, 64'h0, 1'b1);
    add(12'h3A0, 2'd2, 64'h80, 2'b11, 64'h0003_0100_8900_1F0F, 1'b0);
    add(12'h3A0, 2'd3, 64'hFF, 2'b11, 64'h0003_0100_8900_1F8F, 1'b0);
    add(12'h3A0, 2'd0, 64'h0, 2'b11, 64'h0003_0100_8900_1F8F, 1'b0);
    add(12'h3C5, 2'd1, 64'hABCD, 2'b11, 64'h0, 1'b0);
    add(12'h3C5, 2'd0, 64'h0, 2'b11, 64'h0, 1'b0);
    add(12'h3A4, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'h0, 1'b0);
    add(12'h3A4, 2'd0, 64'h0, 2'b11, 64'h0, 1'b0);
    add(12'h3BF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'h0, 1'b0);
    add(12'h3BF, 2'd0, 64'h0, 2'b11, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0);
    add(12'h3A2, 2'd1, 64'h7F, 2'b11, 64'h0, 1'b0);
    add(12'h3A2, 2'd0, 64'h0, 2'b11, 64'h1F, 1'b0);
    add(12'h3A0, 2'd1, 64'h0, 2'b01, 64'h0, 1'b1);

    foreach (tbl[n]) begin
      run_access(tbl[n].adr, tbl[n].op, tbl[n].wd, tbl[n].prv, rd, il, ak);
      model(tbl[n].adr, tbl[n].op, tbl[n].wd, tbl[n].prv, mrd, mil);
      chk($sformatf("vec%0d_ack", n), ak, 1'b1);
      chk($sformatf("vec%0d_rdata", n), rd, tbl[n].rd);
      chk($sformatf("vec%0d_illegal", n), il, tbl[n].ill);
      chk_state($sformatf("vec%0d_state", n));
    end

    // Addresses outside the PMP window never ack.
    foreach (tbl[n]) if (n < 2) begin
      @(negedge clk);
      req = 1'b1; adr = (n == 0) ? 12'h300 : 12'h3F0; op = 2'd1; wd = 64'hFF; prv = 2'b11;
      r = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (ack) r++;
      end
      chk($sformatf("no_ack_outside_%0d", n), r, 0);
      @(negedge clk);
      req = 1'b0;
    end
    chk_state("outside_no_change");

    // Held request: ack, gap, ack.
    model(12'h3A0, 2'd0, 64'h0, 2'b11, mrd, mil);
    @(negedge clk);
    req = 1'b1; adr = 12'h3A0; op = 2'd0; wd = 64'h0; prv = 2'b11;
    @(posedge clk); #1;
    chk("held_ack1", ack, 1'b1);
    @(posedge clk); #1;
    chk("held_gap", ack, 1'b0);
    @(posedge clk); #1;
    chk("held_ack2", ack, 1'b1);
    chk("held_rdata", rdata, mrd);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("held_end", ack, 1'b0);

    // Reset while a request is pending, then the held request after release.
    @(negedge clk);
    req = 1'b1; adr = 12'h3B1; op = 2'd1; wd = 64'h77; prv = 2'b11;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_pending_ack_a", ack, 1'b0);
    @(posedge clk); #1;
    chk("rst_pending_ack_b", ack, 1'b0);
    chk_state("rst_pending_state");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ack", ack, 1'b1);
    chk("rst_release_rdata", rdata, 64'h0);
    model(12'h3B1, 2'd1, 64'h77, 2'b11, mrd, mil);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_end", ack, 1'b0);
    chk_state("rst_release_state");

    // Reset in the ack cycle kills the ack and all state.
    @(negedge clk);
    req = 1'b1; adr = 12'h3B2; op = 2'd1; wd = 64'h55; prv = 2'b11;
    @(posedge clk); #1;
    chk("resp_rst_ack_before", ack, 1'b1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("resp_rst_ack_after", ack, 1'b0);
    chk("resp_rst_rdata", rdata, 64'h0);
    chk_state("resp_rst_state");
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("resp_rst_idle", ack, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
      r = $urandom_range(0, 9);
      if (r < 4)      a = 12'h3A0 + 12'($urandom_range(0, 15));
      else if (r < 8) a = 12'h3B0 + 12'($urandom_range(0, 15));
      else            a = 12'h3C0 + 12'($urandom_range(0, 47));
      o = 2'($urandom_range(0, 3));
      w = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) w = w & 64'h7F7F_7F7F_7F7F_7F7F;
      p = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      run_access(a, o, w, p, rd, il, ak);
      model(a, o, w, p, mrd, mil);
      chk($sformatf("rnd%0d_ack", n), ak, 1'b1);
      chk($sformatf("rnd%0d_rdata_%h", n, a), rd, mrd);
      chk($sformatf("rnd%0d_illegal", n), il, mil);
      chk_state($sformatf("rnd%0d_state", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
